wb_port_arbiter: RTL and testbench

Arbitrates the single register-file writeback slot between the in-order main pipe (ALU/load/CSR/bypass results) and two long-latency units (MUL_DIV, FPU), and produces the registered writeback record that drives the integer and FP register-file write ports. The main pipe has priority, but a bounded starvation counter guarantees forward progress for completed long-latency results. When a long-latency unit must be served, `pipe_ready_o` low is the main-pipe stall source.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_rr2.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared encodings, writeback record type and sizing helper for the writeback-port arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        WB_SRC_PIPE = 2'd0,
        WB_SRC_MD   = 2'd1,
        WB_SRC_FPU  = 2'd2,
        WB_SRC_NONE = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fp;
        wb_src_e     src;
    } wb_rec_t;

    function automatic int starve_cnt_w(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/wb_rr2.sv
// Two-way round-robin picker; the pointer moves past whichever side was granted on advance.
module wb_rr2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic rr_q;
    logic rr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_o = 2'b00;
        if (!rr_q) begin
            gnt_o[0] = req_i[0];
            gnt_o[1] = req_i[1] & ~req_i[0];
        end else begin
            gnt_o[1] = req_i[1];
            gnt_o[0] = req_i[0] & ~req_i[1];
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            rr_d = gnt_o[0];
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback-slot arbiter: main pipe first, MUL_DIV/FPU served round-robin with a starvation bound.
// Build option WB_ARB_FPU_EN: when undefined the FPU port is ignored and MD is the sole LL unit.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        pipe_valid_i,
    output logic        pipe_ready_o,
    input  logic [4:0]  pipe_rd_i,
    input  logic        pipe_fp_i,
    input  logic [31:0] pipe_data_i,
    input  logic        md_valid_i,
    output logic        md_ready_o,
    input  logic [4:0]  md_rd_i,
    input  logic [31:0] md_data_i,
    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic [4:0]  fpu_rd_i,
    input  logic        fpu_fp_i,
    input  logic [31:0] fpu_data_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_reg_wr_en_o,
    output logic        wb_freg_wr_en_o,
    output logic [1:0]  wb_src_o
);

    localparam int               CNT_W   = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             wb_valid_q, wb_valid_d;
    wb_rec_t          wb_rec_q, wb_rec_d;

    logic       fpu_req;
    logic       ll_any;
    logic       starved;
    logic       pipe_gnt;
    logic       ll_gnt;
    logic       md_gnt;
    logic       fpu_gnt;
    logic [1:0] ll_pick;

`ifdef WB_ARB_FPU_EN
    assign fpu_req = fpu_valid_i;

    wb_rr2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({fpu_req, md_valid_i}),
        .advance_i (ll_gnt),
        .gnt_o     (ll_pick)
    );
`else
    logic unused_fpu;
    assign unused_fpu = ^{fpu_valid_i, fpu_rd_i, fpu_fp_i, fpu_data_i};
    assign fpu_req    = 1'b0;
    assign ll_pick    = {1'b0, md_valid_i};
`endif

    // A starved LL result pre-empts the pipe; otherwise LL only fills slots the pipe leaves empty.
    always_comb begin
        ll_any   = md_valid_i | fpu_req;
        starved  = ll_any && (starve_cnt_q == CNT_MAX);
        pipe_gnt = rst_n && !starved && pipe_valid_i && !flush_i;
        ll_gnt   = rst_n && ll_any && !pipe_gnt;
        md_gnt   = ll_gnt & ll_pick[0];
        fpu_gnt  = ll_gnt & ll_pick[1];
    end

    assign pipe_ready_o = pipe_gnt;
    assign md_ready_o   = md_gnt;
    assign fpu_ready_o  = fpu_gnt;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ll_gnt) begin
            starve_cnt_d = '0;
        end else if (pipe_gnt && ll_any && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        wb_valid_d   = pipe_gnt | ll_gnt;
        wb_rec_d     = wb_rec_q;
        wb_rec_d.src = WB_SRC_NONE;
        if (pipe_gnt) begin
            wb_rec_d = '{rd: pipe_rd_i, data: pipe_data_i, fp: pipe_fp_i, src: WB_SRC_PIPE};
        end else if (md_gnt) begin
            wb_rec_d = '{rd: md_rd_i, data: md_data_i, fp: 1'b0, src: WB_SRC_MD};
        end
`ifdef WB_ARB_FPU_EN
        else if (fpu_gnt) begin
            wb_rec_d = '{rd: fpu_rd_i, data: fpu_data_i, fp: fpu_fp_i, src: WB_SRC_FPU};
        end
`endif
    end

    // NOTE: the record datapath is reset too, so a killed in-flight writeback leaves no stale rd/data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rec_q     <= '{rd: '0, data: '0, fp: 1'b0, src: WB_SRC_NONE};
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_rec_q     <= wb_rec_d;
        end
    end

    assign wb_valid_o      = wb_valid_q;
    assign wb_rd_o         = wb_rec_q.rd;
    assign wb_data_o       = wb_rec_q.data;
    assign wb_src_o        = wb_rec_q.src;
    assign wb_reg_wr_en_o  = wb_valid_q & ~wb_rec_q.fp & (wb_rec_q.rd != 5'd0);
    assign wb_freg_wr_en_o = wb_valid_q & wb_rec_q.fp;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (STARVE_MAX = 4); covers both WB_ARB_FPU_EN builds.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        pipe_valid_i, pipe_ready_o;
    logic [4:0]  pipe_rd_i;
    logic        pipe_fp_i;
    logic [31:0] pipe_data_i;
    logic        md_valid_i, md_ready_o;
    logic [4:0]  md_rd_i;
    logic [31:0] md_data_i;
    logic        fpu_valid_i, fpu_ready_o;
    logic [4:0]  fpu_rd_i;
    logic        fpu_fp_i;
    logic [31:0] fpu_data_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_reg_wr_en_o, wb_freg_wr_en_o;
    logic [1:0]  wb_src_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [41:0] obs;
    logic [2:0]  rdy;
    assign obs = {wb_valid_o, wb_reg_wr_en_o, wb_freg_wr_en_o, wb_src_o, wb_rd_o, wb_data_o};
    assign rdy = {pipe_ready_o, md_ready_o, fpu_ready_o};

    wb_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .pipe_valid_i    (pipe_valid_i),
        .pipe_ready_o    (pipe_ready_o),
        .pipe_rd_i       (pipe_rd_i),
        .pipe_fp_i       (pipe_fp_i),
        .pipe_data_i     (pipe_data_i),
        .md_valid_i      (md_valid_i),
        .md_ready_o      (md_ready_o),
        .md_rd_i         (md_rd_i),
        .md_data_i       (md_data_i),
        .fpu_valid_i     (fpu_valid_i),
        .fpu_ready_o     (fpu_ready_o),
        .fpu_rd_i        (fpu_rd_i),
        .fpu_fp_i        (fpu_fp_i),
        .fpu_data_i      (fpu_data_i),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .wb_reg_wr_en_o  (wb_reg_wr_en_o),
        .wb_freg_wr_en_o (wb_freg_wr_en_o),
        .wb_src_o        (wb_src_o)
    );

    always #5 clk = ~clk;

    // Packs an expected output record in the same field order as obs.
    function automatic logic [41:0] rec(input logic v, input logic ie, input logic fe,
                                        input logic [1:0] src, input logic [4:0] rd,
                                        input logic [31:0] d);
        return {v, ie, fe, src, rd, d};
    endfunction

    task automatic drive_idle();
        flush_i      = 1'b0;
        pipe_valid_i = 1'b0; pipe_rd_i = 5'd0; pipe_fp_i = 1'b0; pipe_data_i = 32'd0;
        md_valid_i   = 1'b0; md_rd_i   = 5'd0; md_data_i = 32'd0;
        fpu_valid_i  = 1'b0; fpu_rd_i  = 5'd0; fpu_fp_i  = 1'b0; fpu_data_i  = 32'd0;
    endtask

    task automatic pulse_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'hdead; md_valid_i = 1'b1;
        fpu_valid_i = 1'b1;
        #1;
        n_checks++;
        if (rdy !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 000", rdy);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd0, 32'd0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp %h", obs,
                               rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd0, 32'd0));
        end
        rst_n = 1'b1;
        drive_idle();
    endtask

    task automatic test_pipe_only();
        logic [41:0] exp_o;
        logic [2:0]  exp_r;
        for (int i = 0; i < 4; i++) begin
            pipe_valid_i = (i < 3); pipe_rd_i = 5'd5; pipe_fp_i = 1'b0; pipe_data_i = 32'h1234;
            exp_r = (i < 3) ? 3'b100 : 3'b000;
            exp_o = (i < 3) ? rec(1'b1, 1'b1, 1'b0, WB_SRC_PIPE, 5'd5, 32'h1234)
                            : rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd5, 32'h1234);
            #1;
            n_checks++;
            if (rdy !== exp_r) begin
                n_fail++; $display("FAIL pipe_only_ready[%0d]: got %b exp %b", i, rdy, exp_r);
            end
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++; $display("FAIL pipe_only_wb[%0d]: got %h exp %h", i, obs, exp_o);
            end
        end
        drive_idle();
    endtask

    // Counter starts at 0: four pipe grants, then MD is forced through with the pipe stalled.
    task automatic test_starvation();
        logic [41:0] exp_o;
        logic [2:0]  exp_r;
        logic        exp_md;
        for (int i = 0; i < 10; i++) begin
            pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'(32'hA0 + i);
            md_valid_i   = 1'b1; md_rd_i   = 5'd7; md_data_i   = 32'hB00;
            exp_md = ((i % 5) == 4);
            exp_r  = exp_md ? 3'b010 : 3'b100;
            exp_o  = exp_md ? rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd7, 32'hB00)
                            : rec(1'b1, 1'b1, 1'b0, WB_SRC_PIPE, 5'd3, 32'(32'hA0 + i));
            #1;
            n_checks++;
            if (rdy !== exp_r) begin
                n_fail++; $display("FAIL starve_ready[%0d]: got %b exp %b", i, rdy, exp_r);
            end
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++; $display("FAIL starve_wb[%0d]: got %h exp %h", i, obs, exp_o);
            end
        end
        drive_idle();
    endtask

    task automatic test_ll_arbitration();
        logic [41:0] exp_o;
        logic [2:0]  exp_r;
`ifdef WB_ARB_FPU_EN
        pulse_reset();
`endif
        for (int i = 0; i < 6; i++) begin
            md_valid_i  = 1'b1; md_rd_i  = 5'd8; md_data_i  = 32'hD0;
            fpu_valid_i = 1'b1; fpu_rd_i = 5'd9; fpu_fp_i = 1'b1; fpu_data_i = 32'hF0;
`ifdef WB_ARB_FPU_EN
            exp_r = (i % 2 == 1) ? 3'b001 : 3'b010;
            exp_o = (i % 2 == 1) ? rec(1'b1, 1'b0, 1'b1, WB_SRC_FPU, 5'd9, 32'hF0)
                                 : rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd8, 32'hD0);
`else
            exp_r = 3'b010;
            exp_o = rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd8, 32'hD0);
`endif
            #1;
            n_checks++;
            if (rdy !== exp_r) begin
                n_fail++; $display("FAIL ll_ready[%0d]: got %b exp %b", i, rdy, exp_r);
            end
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++; $display("FAIL ll_wb[%0d]: got %h exp %h", i, obs, exp_o);
            end
        end
        drive_idle();
    endtask

    task automatic test_flush();
        logic [41:0] exp_o;
        logic [2:0]  exp_r;
        flush_i = 1'b1;
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd9; pipe_data_i = 32'h55;
        fpu_valid_i  = 1'b1; fpu_rd_i  = 5'd0; fpu_fp_i = 1'b1; fpu_data_i = 32'h77;
`ifdef WB_ARB_FPU_EN
        exp_r = 3'b001;
        exp_o = rec(1'b1, 1'b0, 1'b1, WB_SRC_FPU, 5'd0, 32'h77);
`else
        exp_r = 3'b000;
        exp_o = rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd8, 32'hD0);
`endif
        #1;
        n_checks++;
        if (rdy !== exp_r) begin
            n_fail++; $display("FAIL flush_fpu_ready: got %b exp %b", rdy, exp_r);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== exp_o) begin
            n_fail++; $display("FAIL flush_fpu_wb: got %h exp %h", obs, exp_o);
        end
        fpu_valid_i = 1'b0;
        md_valid_i  = 1'b1; md_rd_i = 5'd6; md_data_i = 32'h66;
        #1;
        n_checks++;
        if (rdy !== 3'b010) begin
            n_fail++; $display("FAIL flush_md_ready: got %b exp 010", rdy);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd6, 32'h66)) begin
            n_fail++; $display("FAIL flush_md_wb: got %h exp %h", obs,
                               rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd6, 32'h66));
        end
        drive_idle();
    endtask

    task automatic test_rd_zero();
        logic [41:0] exp_o;
        for (int i = 0; i < 2; i++) begin
            pipe_valid_i = 1'b1; pipe_rd_i = 5'd0; pipe_fp_i = (i == 1);
            pipe_data_i  = (i == 1) ? 32'h3f80_0000 : 32'h99;
            exp_o = (i == 1) ? rec(1'b1, 1'b0, 1'b1, WB_SRC_PIPE, 5'd0, 32'h3f80_0000)
                             : rec(1'b1, 1'b0, 1'b0, WB_SRC_PIPE, 5'd0, 32'h99);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++; $display("FAIL rd_zero_wb[%0d]: got %h exp %h", i, obs, exp_o);
            end
        end
        drive_idle();
    endtask

    // Counter reaches 3, reset hits, then a full four-grant run must precede the MD grant.
    task automatic test_reset_midseq();
        logic [41:0] exp_o;
        logic        exp_md;
        pipe_valid_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'hC0;
        md_valid_i   = 1'b1; md_rd_i   = 5'd7; md_data_i   = 32'hB00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== rec(1'b1, 1'b1, 1'b0, WB_SRC_PIPE, 5'd3, 32'hC0)) begin
                n_fail++; $display("FAIL midseq_pre[%0d]: got %h exp %h", i, obs,
                                   rec(1'b1, 1'b1, 1'b0, WB_SRC_PIPE, 5'd3, 32'hC0));
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rdy !== 3'b000) begin
            n_fail++; $display("FAIL midseq_reset_ready: got %b exp 000", rdy);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd0, 32'd0)) begin
            n_fail++; $display("FAIL midseq_reset_wb: got %h exp %h", obs,
                               rec(1'b0, 1'b0, 1'b0, WB_SRC_NONE, 5'd0, 32'd0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_md = (i == 4);
            exp_o  = exp_md ? rec(1'b1, 1'b1, 1'b0, WB_SRC_MD, 5'd7, 32'hB00)
                            : rec(1'b1, 1'b1, 1'b0, WB_SRC_PIPE, 5'd3, 32'hC0);
            @(negedge clk);
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++; $display("FAIL midseq_post[%0d]: got %h exp %h", i, obs, exp_o);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_pipe_only();
        test_starvation();
        test_ll_arbitration();
        test_flush();
        test_rd_zero();
        test_reset_midseq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
